ipm_unmask: RTL and testbench
=============================

# ipm_unmask

Downstream consumer of the IPM coprocessor's share vector. Recombines the N = n−k+1 inner-product-masked shares into the plain byte Z = ⊕ L'[i]·Z[i] over GF(2^8), using the fixed public vector L'. Used for debug readback and for the final unmasking step before results leave the protected domain. Uses one shared gfmul instance (AES polynomial 0x11B) iterated over the shares, one share per cycle.

## Interface
- n, 4: masking order parameter, identical to the IPM unit's n.
- k, 1: the IPM unit's k. Only k = 1 is supported; other values are an elaboration error.
- N (localparam), n−k+1: number of shares (4 by default).
- WIDTH (localparam), N*8: share-vector width.
- clk_i  in  1  clock. One clock domain.
- reset_ni  in  1  reset. Asynchronous, active-low.
- start_i  in  1  request to unmask shares_i. Sampled only in IDLE.
- shares_i  in  WIDTH  share vector, same packing as the IPM result. Share i is at [WIDTH−1−8i −: 8], so share 0 is in the MSB byte.
- busy_o  out  1  high whenever state ≠ IDLE.
- valid_o  out  1  one-cycle pulse; result_o is new and valid.
- result_o  out  8  unmasked byte. Held until the next completion.

## Operation
- Constants: L'[0..3] = 1, 27 (0x1B), 250 (0xFA), 188 (0xBC).
- FSM states: IDLE, ACC, DONE. Internal registers:
  - sh_q[0..N−1]: captured shares.
  - acc_q: 8-bit accumulator.
  - idx_q: $clog2(N) bits.
  - res_q: 8-bit output register.
- IDLE:
  - On start_i = 1: capture shares_i into sh_q, set acc_q ← 0 and idx_q ← 0, go to ACC.
  - Otherwise remain in IDLE; all registers hold.
- ACC, one step per cycle:
  - Multiplier inputs: rs1 = L'[idx_q], rs2 = sh_q[idx_q].
  - acc_q ← acc_q ⊕ gfmul result.
  - If idx_q = N−1: res_q ← acc_q ⊕ gfmul result, go to DONE. Otherwise idx_q ← idx_q + 1.
  - idx_q never wraps past N−1.
- DONE: valid_o = 1, go to IDLE unconditionally.
- start_i in ACC or DONE is ignored. It is not queued; the requester must wait for busy_o = 0.
- shares_i is not required to be stable after the start cycle, because it is captured.
- When idle, the gfmul inputs are driven to 0, so there is no toggling on stale shares.
- All arithmetic is 8-bit XOR/GF(2^8). There is no carry and no overflow.

## Timing
- Reset values:
  - state = IDLE; busy_o = 0; valid_o = 0; result_o = 0x00.
  - sh_q, acc_q and idx_q = 0.
- Latency, with start_i sampled at clock edge t:
  - busy_o is high from edge t through edge t+N+1.
  - ACC occupies cycles t+1 … t+N.
  - valid_o is high for exactly the cycle after edge t+N, i.e. the (N+1)th cycle after acceptance; that is 5 cycles for N = 4.
  - result_o changes on that same edge and stays valid from it onward.
- Throughput: one unmask per N+2 cycles. A start_i held high continuously is accepted again in the first IDLE cycle after DONE.
- valid_o is a registered decode of state = DONE. It is never high for two consecutive cycles.
- Reset asserted mid-operation:
  - Immediate return to IDLE; busy_o = 0, valid_o = 0, result_o = 0x00.
  - No partial result is ever published.
- Start in the same cycle that reset deasserts: ignored unless sampled at a rising edge with reset_ni = 1.

## Test plan
- Reset, then shares_i = 0x5A000000 with start_i pulsed one cycle:
  - busy_o rises on the next edge.
  - valid_o pulses exactly 5 cycles after acceptance.
  - result_o = 0x5A.
- Single-share weights, run one after another:
  - 0x00010000 → 0x1B.
  - 0x00000100 → 0xFA.
  - 0x00000001 → 0xBC.
  - 0x00020000 → 0x36.
- shares_i = 0x01010101 → result_o = 0x5C. Then change shares_i to 0xFFFFFFFF on the cycle after start → result is still 0x5C, confirming capture.
- Start 0x5A000000, then pulse start_i with 0x00010000 during ACC and again during DONE:
  - Both extra pulses are ignored; a single valid_o with 0x5A.
  - A new start after busy_o falls returns 0x1B.
- Hold start_i high for 20 cycles with 0x01010101:
  - valid_o pulses every 6 cycles, each with 0x5C.
  - busy_o is low for exactly one cycle between runs.
- Assert reset_ni low in the 2nd ACC cycle, release, then start 0x000000BC → no valid_o after the aborted run. After reset, result_o = 0x00 until the new run completes; then result_o = gfmul(0xBC, 0xBC), checked against the reference model.

Source files
------------

// File: rtl/ipm_unmask_if.sv
// ipm_unmask_if: start/share-vector request and unmasked-byte response bundle
interface ipm_unmask_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [WIDTH-1:0] shares_i;
  logic             busy_o;
  logic             valid_o;
  logic [7:0]       result_o;
  modport master (output start_i, shares_i, input busy_o, valid_o, result_o);
  modport slave (input start_i, shares_i, output busy_o, valid_o, result_o);
endinterface

// File: rtl/ipm_unmask.sv
// ipm_unmask: recombines IPM shares into Z = xor_i L'[i]*Z[i] over GF(2^8), one share per cycle
module ipm_unmask #(
  parameter int n = 4,
  parameter int k = 1
) (
  input logic         clk_i,
  input logic         reset_ni,
  ipm_unmask_if.slave bus
);
  localparam int N = n - k + 1;
  localparam int WIDTH = N * 8;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [7:0] LP [4] = '{8'h01, 8'h1B, 8'hFA, 8'hBC};

  if (k != 1 || N < 2 || N > 4) begin : g_bad_param
    $error("ipm_unmask supports only k = 1 and 2 <= n <= 4");
  end

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    sh_q [N];
  logic [7:0]    acc_q, acc_d, res_q, res_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, cap;
  logic [7:0]    rs1, rs2, prod;

  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplier inputs are forced to zero outside ACC so stale shares never toggle it.
  assign rs1  = (state_q == ACC) ? LP[idx_q] : 8'h00;
  assign rs2  = (state_q == ACC) ? sh_q[idx_q] : 8'h00;
  assign prod = gfmul(rs1, rs2);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = ACC;
        acc_d   = '0;
        idx_d   = '0;
        cap     = 1'b1;
      end
      ACC: begin
        acc_d = acc_q ^ prod;
        if (idx_q == LAST) begin
          res_d   = acc_q ^ prod;
          state_d = DONE;
        end else idx_d = idx_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < N; i++) sh_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      valid_q <= (state_d == DONE);
      if (cap) for (int i = 0; i < N; i++) sh_q[i] <= bus.shares_i[WIDTH-1-8*i -: 8];
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.valid_o  = valid_q;
  assign bus.result_o = res_q;
endmodule

// File: tb/tb_ipm_unmask.sv
// tb_ipm_unmask: scoreboard bench for ipm_unmask against an independent GF(2^8) model
module tb_ipm_unmask;
  logic clk, rst_n;
  int   n_tests = 0, n_fail = 0, n_valid = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q [$];

  ipm_unmask_if #(.WIDTH(32)) bus ();

  ipm_unmask #(.n(4), .k(1)) dut (.clk_i(clk), .reset_ni(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11B << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] model(input logic [31:0] s);
    logic [7:0] lp [4];
    logic [7:0] z;
    lp = '{8'h01, 8'h1B, 8'hFA, 8'hBC};
    z = '0;
    for (int i = 0; i < 4; i++) z ^= ref_mul(lp[i], s[31-8*i -: 8]);
    return z;
  endfunction

  always @(negedge clk) begin
    if (bus.valid_o) begin
      n_valid++;
      if (exp_q.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
      else chk("result", 32'(bus.result_o), 32'(exp_q.pop_front()));
      if (prev_valid) chk("valid_back_to_back", 32'd1, 32'd0);
    end
    prev_valid = bus.valid_o;
  end

  // Called at a negedge with the DUT idle; returns at the first idle negedge after completion.
  task automatic run(input logic [31:0] s, input logic [31:0] after);
    int lat;
    bus.start_i  = 1'b1;
    bus.shares_i = s;
    exp_q.push_back(model(s));
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.shares_i = after;
    chk("busy_rise", 32'(bus.busy_o), 32'd1);
    lat = 1;
    while (!bus.valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 5);
    @(negedge clk);
    chk("busy_fall", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int v0, lat, lows, vlast, vcnt;
    logic [31:0] singles [4];
    rst_n        = 1'b0;
    bus.start_i  = 1'b0;
    bus.shares_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_result", 32'(bus.result_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h5A000000, 32'h5A000000);
    chk("res_5a", 32'(bus.result_o), 32'h5A);
    singles = '{32'h00010000, 32'h00000100, 32'h00000001, 32'h00020000};
    foreach (singles[i]) run(singles[i], singles[i]);
    chk("res_36", 32'(bus.result_o), 32'h36);
    run(32'h01010101, 32'hFFFFFFFF);
    chk("res_capture", 32'(bus.result_o), 32'h5C);
    // Extra starts during ACC and DONE must be dropped.
    v0 = n_valid;
    bus.start_i  = 1'b1;
    bus.shares_i = 32'h5A000000;
    exp_q.push_back(model(32'h5A000000));
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.shares_i = 32'h00010000;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 0;
    while (!bus.valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore_wait", 32'(bus.valid_o), 32'd1);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignore_count", n_valid - v0, 1);
    chk("ignore_queue", exp_q.size(), 0);
    run(32'h00010000, 32'h00010000);
    chk("after_ignore", 32'(bus.result_o), 32'h1B);
    // Continuous start: accepted at edges 1, 7, 13 and 19.
    v0 = n_valid;
    bus.start_i  = 1'b1;
    bus.shares_i = 32'h01010101;
    repeat (4) exp_q.push_back(model(32'h01010101));
    lows = 0;
    vlast = 0;
    vcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 20) bus.start_i = 1'b0;
      if (bus.valid_o) begin
        if (vcnt == 0) chk("hold_first", i, 5);
        else chk("hold_period", i - vlast, 6);
        vlast = i;
        vcnt++;
      end
      if (i >= 2 && i <= 23 && !bus.busy_o) begin
        lows++;
        chk("hold_gap_pos", i % 6, 0);
      end
    end
    chk("hold_runs", n_valid - v0, 4);
    chk("hold_gaps", lows, 3);
    // Reset in the 2nd ACC cycle aborts the run without publishing anything.
    v0 = n_valid;
    bus.start_i  = 1'b1;
    bus.shares_i = 32'h01010101;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_valid", 32'(bus.valid_o), 32'd0);
    chk("abort_result", 32'(bus.result_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_valid", n_valid - v0, 0);
    chk("abort_result_hold", 32'(bus.result_o), 32'd0);
    run(32'h000000BC, 32'h000000BC);
    chk("res_bc", 32'(bus.result_o), 32'(ref_mul(8'hBC, 8'hBC)));
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
